wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone arbiter. Shares one slave port, such as the ddr0 controller, among N_MASTERS bus masters (lm32 data port, DMA, video fetch).
- Sits between the masters and the slave, in front of or in place of a single conbus slave port.
- Holds a grant for the whole m_cyc_i envelope of the owning master.
- Includes a bus-timeout watchdog that terminates hung slave cycles with err.

Parameters:
- N_MASTERS, 4, number of requesting masters (2..8).
- ADR_W, 32, address width.
- DAT_W, 32, data width; sel width is DAT_W/8.
- TIMEOUT, 1024, cycles stb may wait for ack/err before forced err; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- m_cyc_i  in  N_MASTERS  per-master cyc
- m_stb_i  in  N_MASTERS  per-master stb
- m_we_i  in  N_MASTERS  per-master we
- m_adr_i  in  N_MASTERS*ADR_W  packed addresses; master k at [k*ADR_W +: ADR_W]
- m_dat_i  in  N_MASTERS*DAT_W  packed write data
- m_sel_i  in  N_MASTERS*DAT_W/8  packed byte selects
- m_dat_o  out  DAT_W  read data, broadcast to all masters (= s_dat_i)
- m_ack_o  out  N_MASTERS  per-master ack
- m_err_o  out  N_MASTERS  per-master err
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
- s_adr_o  out  ADR_W  to slave
- s_dat_o  out  DAT_W  to slave
- s_sel_o  out  DAT_W/8  to slave
- s_dat_i  in  DAT_W  from slave
- s_ack_i, s_err_i  in  1 each  from slave
- gnt_o  out  N_MASTERS  one-hot current grant; all zero when idle
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- State register values: IDLE, BUSY. Registered owner index `own`, last owner `last`, watchdog counter `cnt` (clog2(TIMEOUT+1) bits).
- Reset: state=IDLE, last=N_MASTERS-1 (master 0 wins first), cnt=0. Resulting outputs:
  - s_cyc_o=s_stb_o=s_we_o=0; s_adr_o, s_dat_o, s_sel_o = 0.
  - m_ack_o=m_err_o=0, gnt_o=0, timeout_o=0.
- Reset asserted mid-transfer: grant is dropped and s_cyc_o is low from the cycle after the rst edge. No ack or err is delivered to the interrupted master.
- IDLE:
  - Slave outputs are all zero.
  - If any m_cyc_i bit is set, own <= first set index scanning (last+1), (last+2), ... modulo N_MASTERS; state <= BUSY.
  - Grant latency is 1 cycle: cyc seen in cycle t, s_cyc_o high in cycle t+1.
- BUSY, slave side:
  - s_cyc_o = m_cyc_i[own]; s_stb_o = m_stb_i[own] & m_cyc_i[own].
  - s_we_o, s_adr_o, s_dat_o, s_sel_o are combinational muxes of master `own`.
- BUSY, master side:
  - m_ack_o[own] = s_ack_i; m_err_o[own] = s_err_i | watchdog_fire.
  - All other m_ack_o/m_err_o bits are 0.
- BUSY exit: when m_cyc_i[own]==0, state <= IDLE and last <= own.
  - That cycle already drives s_cyc_o=0.
  - Consecutive owners are separated by exactly one IDLE cycle.
- Ack/err arriving while stb is low or cyc is low: still routed to owner; the arbiter ignores it.
- Requests from non-owners are held off: no ack, no err.
- A master may run bursts and back-to-back stb within one cyc; the grant persists throughout.
- Watchdog (TIMEOUT>0):
  - In BUSY with s_stb_o=1 and s_ack_i=s_err_i=0, cnt increments. Otherwise cnt <= 0.
  - When cnt==TIMEOUT, watchdog_fire=1 that cycle, with these effects:
    - m_err_o[own]=1 and timeout_o=1.
    - s_cyc_o and s_stb_o are forced 0 for that cycle.
    - cnt <= 0.
  - The master keeps the grant until it drops cyc.
  - If s_ack_i and watchdog_fire coincide, ack wins: no err, counter clears.
- Simultaneous cyc assertion by several masters in IDLE: only the round-robin winner is granted. The others wait, holding cyc.
- A single master requesting repeatedly is re-granted every time (work-conserving).

Test Plan:
- Reset, then m_cyc_i=4'b0001 with stb; slave ack after 2 cycles. Required: gnt_o=0001 one cycle after cyc; m_ack_o=0001 in the slave ack cycle; gnt_o=0 the cycle after cyc drops.
- m_cyc_i=4'b1111 held for 4 single-access transactions. Required: grant order 0,1,2,3; one idle cycle between grants; no overlapping gnt_o bits.
- Master 2 owns the bus while master 0 requests. Required: master 0 sees no ack/err until master 2 drops cyc; master 0 is granted next, not master 3.
- TIMEOUT=8, slave never acks. Required: m_err_o[own] and timeout_o are 1 on the 9th stb cycle; s_cyc_o=0 that cycle; cnt restarts at 0.
- Ack arrives on the same cycle cnt==TIMEOUT. Required: m_ack_o=1, m_err_o=0, timeout_o=0.
- rst asserted while master 1 is mid-burst. Required: s_cyc_o=0 and gnt_o=0 next cycle; after release with m_cyc_i=4'b0011, master 0 is granted first.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave port.
// Grant lasts for the owner's whole cyc envelope; watchdog ends hung cycles.
module wb_rr_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int ADR_W     = 32,
  parameter int DAT_W     = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MASTERS-1:0]         m_cyc_i,
  input  logic [N_MASTERS-1:0]         m_stb_i,
  input  logic [N_MASTERS-1:0]         m_we_i,
  input  logic [N_MASTERS*ADR_W-1:0]   m_adr_i,
  input  logic [N_MASTERS*DAT_W-1:0]   m_dat_i,
  input  logic [N_MASTERS*DAT_W/8-1:0] m_sel_i,
  output logic [DAT_W-1:0]             m_dat_o,
  output logic [N_MASTERS-1:0]         m_ack_o,
  output logic [N_MASTERS-1:0]         m_err_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  output logic                         s_we_o,
  output logic [ADR_W-1:0]             s_adr_o,
  output logic [DAT_W-1:0]             s_dat_o,
  output logic [DAT_W/8-1:0]           s_sel_o,
  input  logic [DAT_W-1:0]             s_dat_i,
  input  logic                         s_ack_i,
  input  logic                         s_err_i,
  output logic [N_MASTERS-1:0]         gnt_o,
  output logic                         timeout_o
);

  localparam int SEL_W = DAT_W / 8;
  localparam int OW    = $clog2(N_MASTERS);
  localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_n;
  logic [OW-1:0] own, own_n;
  logic [OW-1:0] last, last_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [OW-1:0] pick;
  logic          pick_vld;
  logic          own_cyc;
  logic          own_stb;
  logic          fire;

  assign m_dat_o = s_dat_i;

  // Round-robin winner: nearest requester after the last owner.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int d = N_MASTERS; d >= 1; d--) begin
      int idx;
      idx = (int'(last) + d) % N_MASTERS;
      if (m_cyc_i[idx]) begin
        pick     = OW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // Next state, slave mux, master responses and watchdog.
  always_comb begin
    state_n   = state;
    own_n     = own;
    last_n    = last;
    cnt_n     = '0;
    fire      = 1'b0;
    own_cyc   = m_cyc_i[own];
    own_stb   = m_stb_i[own] & m_cyc_i[own];
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    gnt_o     = '0;
    timeout_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          state_n = BUSY;
          own_n   = pick;
        end
      end
      BUSY: begin
        gnt_o[own] = 1'b1;
        fire = (TIMEOUT > 0) && own_stb &&
               (cnt == CW'(TIMEOUT)) && !s_ack_i;
        s_cyc_o = own_cyc & ~fire;
        s_stb_o = own_stb & ~fire;
        s_we_o  = m_we_i[own];
        s_adr_o = m_adr_i[own*ADR_W +: ADR_W];
        s_dat_o = m_dat_i[own*DAT_W +: DAT_W];
        s_sel_o = m_sel_i[own*SEL_W +: SEL_W];
        m_ack_o[own] = s_ack_i;
        m_err_o[own] = s_err_i | fire;
        timeout_o    = fire;
        if ((TIMEOUT > 0) && s_stb_o && !s_ack_i && !s_err_i)
          cnt_n = cnt + 1'b1;
        if (!own_cyc) begin
          state_n = IDLE;
          last_n  = own;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, owner, last owner and watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      own   <= '0;
      last  <= OW'(N_MASTERS - 1);
      cnt   <= '0;
    end else begin
      state <= state_n;
      own   <= own_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios then random traffic,
// all outputs compared every cycle against a behavioural model.
module tb_wb_rr_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic         clk;
  logic         rst;
  logic [3:0]   m_cyc, m_stb, m_we;
  logic [127:0] m_adr, m_dat;
  logic [15:0]  m_sel;
  logic [31:0]  m_dat_o;
  logic [3:0]   m_ack, m_err;
  logic         s_cyc, s_stb, s_we;
  logic [31:0]  s_adr, s_dat_o;
  logic [3:0]   s_sel;
  logic [31:0]  s_dat_i;
  logic         s_ack, s_err;
  logic [3:0]   gnt;
  logic         tmo;

  int checks = 0;
  int errors = 0;

  bit mb;
  int mo, ml, mw;
  bit mfire;

  wb_rr_arbiter #(
    .N_MASTERS(N), .ADR_W(32), .DAT_W(32), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err),
    .gnt_o(gnt), .timeout_o(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Compare every output with the model at the falling edge.
  task automatic peek();
    logic [3:0]  e_gnt, e_ack, e_err, e_sel;
    logic        e_cyc, e_stb, e_we;
    logic [31:0] e_adr, e_dat;
    bit oc, os;
    @(negedge clk);
    e_gnt = '0; e_ack = '0; e_err = '0; e_sel = '0;
    e_cyc = 0; e_stb = 0; e_we = 0; e_adr = '0; e_dat = '0;
    mfire = 0;
    if (mb) begin
      oc = m_cyc[mo];
      os = oc && m_stb[mo];
      mfire = os && (mw == TO) && !s_ack;
      e_gnt[mo] = 1'b1;
      e_cyc = oc && !mfire;
      e_stb = os && !mfire;
      e_we  = m_we[mo];
      e_adr = m_adr[mo*32 +: 32];
      e_dat = m_dat[mo*32 +: 32];
      e_sel = m_sel[mo*4 +: 4];
      e_ack[mo] = s_ack;
      e_err[mo] = s_err || mfire;
    end
    chk("gnt", 64'(gnt), 64'(e_gnt));
    chk("s_cyc", 64'(s_cyc), 64'(e_cyc));
    chk("s_stb", 64'(s_stb), 64'(e_stb));
    chk("s_we", 64'(s_we), 64'(e_we));
    chk("s_adr", 64'(s_adr), 64'(e_adr));
    chk("s_dat", 64'(s_dat_o), 64'(e_dat));
    chk("s_sel", 64'(s_sel), 64'(e_sel));
    chk("m_ack", 64'(m_ack), 64'(e_ack));
    chk("m_err", 64'(m_err), 64'(e_err));
    chk("timeout", 64'(tmo), 64'(mfire));
    chk("m_dat", 64'(m_dat_o), 64'(s_dat_i));
  endtask

  // Advance the model across the rising edge.
  task automatic adv();
    @(posedge clk);
    if (rst) begin
      mb = 0; ml = N - 1; mw = 0;
    end else if (!mb) begin
      mw = 0;
      for (int d = 1; d <= N; d++) begin
        if (m_cyc[(ml + d) % N]) begin
          mo = (ml + d) % N;
          mb = 1;
          break;
        end
      end
    end else begin
      if (m_cyc[mo] && m_stb[mo] && !mfire && !s_ack && !s_err)
        mw++;
      else
        mw = 0;
      if (!m_cyc[mo]) begin
        mb = 0;
        ml = mo;
      end
    end
    #1;
  endtask

  task automatic rand_data();
    m_we    = 4'($urandom);
    m_adr   = {$urandom, $urandom, $urandom, $urandom};
    m_dat   = {$urandom, $urandom, $urandom, $urandom};
    m_sel   = 16'($urandom);
    s_dat_i = $urandom;
  endtask

  initial begin
    rst = 1; m_cyc = 0; m_stb = 0; s_ack = 0; s_err = 0;
    rand_data();
    @(posedge clk);
    mb = 0; ml = N - 1; mw = 0; mo = 0;
    #1;
    peek();
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_cyc", 64'(s_cyc), 64'(0));
    chk("rst_adr", 64'(s_adr), 64'(0));
    adv();
    rst = 0;

    // Single master, ack after two stall cycles.
    m_cyc = 4'b0001; m_stb = 4'b0001;
    peek(); chk("t1_idle", 64'(gnt), 64'(0)); adv();
    peek(); chk("t1_gnt", 64'(gnt), 64'(4'b0001));
    chk("t1_scyc", 64'(s_cyc), 64'(1)); adv();
    peek(); adv();
    s_ack = 1;
    peek(); chk("t1_ack", 64'(m_ack), 64'(4'b0001)); adv();
    s_ack = 0; m_cyc = 0; m_stb = 0;
    peek(); chk("t1_drop", 64'(s_cyc), 64'(0)); adv();
    peek(); chk("t1_gnt0", 64'(gnt), 64'(0)); adv();

    // All four request; expect grant order 0,1,2,3.
    rst = 1; peek(); adv(); rst = 0;
    m_cyc = 4'b1111; m_stb = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      s_ack = 0;
      peek(); chk("t2_gap", 64'(gnt), 64'(0)); adv();
      s_ack = 1;
      peek(); chk("t2_gnt", 64'(gnt), 64'(1 << k));
      chk("t2_ack", 64'(m_ack), 64'(1 << k)); adv();
      s_ack = 0; m_cyc[k] = 0; m_stb[k] = 0;
      peek(); chk("t2_exit", 64'(s_cyc), 64'(0)); adv();
    end

    // Master 2 owns while master 0 waits; 0 wins next, not 3.
    m_cyc = 4'b0100; m_stb = 4'b0100;
    peek(); adv();
    m_cyc = 4'b0101; m_stb = 4'b0101;
    peek(); chk("t3_gnt2", 64'(gnt), 64'(4'b0100)); adv();
    s_ack = 1;
    peek(); chk("t3_ack", 64'(m_ack), 64'(4'b0100)); adv();
    s_ack = 0; s_err = 1;
    peek(); chk("t3_err", 64'(m_err), 64'(4'b0100)); adv();
    s_err = 0; m_cyc = 4'b0001; m_stb = 4'b0001;
    peek(); adv();
    peek(); chk("t3_gap", 64'(gnt), 64'(0)); adv();
    peek(); chk("t3_gnt0", 64'(gnt), 64'(4'b0001)); adv();
    m_cyc = 0; m_stb = 0;
    peek(); adv(); peek(); adv();

    // Watchdog: slave never answers master 1.
    m_cyc = 4'b0010; m_stb = 4'b0010;
    peek(); adv();
    for (int j = 0; j < TO; j++) begin
      peek(); chk("t4_quiet", 64'(tmo), 64'(0)); adv();
    end
    peek();
    chk("t4_err", 64'(m_err), 64'(4'b0010));
    chk("t4_to", 64'(tmo), 64'(1));
    chk("t4_scyc", 64'(s_cyc), 64'(0)); adv();
    // Counter restarted: ack lands exactly when it hits the limit.
    for (int j = 0; j < TO; j++) begin
      peek(); chk("t5_quiet", 64'(tmo), 64'(0)); adv();
    end
    s_ack = 1;
    peek();
    chk("t5_ack", 64'(m_ack), 64'(4'b0010));
    chk("t5_err", 64'(m_err), 64'(0));
    chk("t5_to", 64'(tmo), 64'(0)); adv();
    s_ack = 0;

    // Reset in the middle of master 1's burst.
    rst = 1; peek(); adv(); rst = 0;
    m_cyc = 4'b0011; m_stb = 4'b0011;
    peek(); chk("t6_scyc", 64'(s_cyc), 64'(0));
    chk("t6_gnt", 64'(gnt), 64'(0)); adv();
    peek(); chk("t6_gnt0", 64'(gnt), 64'(4'b0001)); adv();
    m_cyc = 0; m_stb = 0;
    peek(); adv(); peek(); adv();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) m_cyc[b] = ~m_cyc[b];
      m_stb = 4'($urandom);
      s_ack = ($urandom_range(0, 3) == 0);
      s_err = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) begin
        s_ack = 0; s_err = 0;
      end
      rand_data();
      peek(); adv();
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
